alu_exec_ctrl: RTL and testbench

Multi-cycle execute controller that sits directly upstream of the combinational alu (WIDTH-parameterised; opCode 00 add, 01 mul, 10 div).
- Accepts one operation at a time from decode over a valid/ready handshake.
- Registers the operands into the alu and holds them stable for a per-op settle window, since mul/div are multicycle paths.
- Captures result and flags, then presents them to writeback over valid/ready.
- Maintains the architectural NZCV status register.

---
 rtl/alu_exec_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for the multi-cycle alu: accepts one op from decode,
// holds alu operands for the op's settle window, captures result/flags, hands off to writeback.
//
// state | meaning
// IDLE  | ready for a new op from decode
// EXEC  | operands held on alu, settle counter running down
// DONE  | result presented to writeback, waiting for out_ready
module alu_exec_ctrl #(
    parameter int WIDTH   = 23,
    parameter int ADD_CYC = 1,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_a,
    input  logic [WIDTH:0]   in_b,
    input  logic [1:0]       in_op,
    input  logic             in_ci,
    input  logic             in_setflags,
    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [1:0]       alu_opCode,
    output logic             alu_ci,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_co,
    input  logic             alu_negativo,
    input  logic             alu_cero,
    input  logic             alu_acarreo,
    input  logic             alu_desbordamiento,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic             out_co,
    output logic             out_err,
    output logic [3:0]       flags_nzcv
);

    localparam int MAX_AM = (ADD_CYC > MUL_CYC) ? ADD_CYC : MUL_CYC;
    localparam int MAX_C  = (MAX_AM > DIV_CYC) ? MAX_AM : DIV_CYC;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] ADD_LD = CNT_W'(ADD_CYC - 1);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;
    logic             setflags_q;
    logic             err_q;
    logic             accept;
    logic             op_err;
    logic             capture;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign op_err    = (in_op == 2'b11) || ((in_op == 2'b10) && (in_b == '0));
    assign capture   = (state == EXEC) && (cnt == '0);
    assign out_valid = (state == DONE);

    always_comb begin
        load_val = ADD_LD;
        case (in_op)
            2'b01:   load_val = MUL_LD;
            2'b10:   load_val = DIV_LD;
            default: load_val = ADD_LD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (cnt == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Error ops spend one pass through EXEC with a zero count so they report
    // one cycle after accept, same as the fastest legal op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opCode <= 2'b00;
            alu_ci     <= 1'b0;
            setflags_q <= 1'b0;
            err_q      <= 1'b0;
            out_result <= '0;
            out_co     <= 1'b0;
            out_err    <= 1'b0;
            flags_nzcv <= 4'b0000;
        end else begin
            if (accept) begin
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_opCode <= in_op;
                alu_ci     <= in_ci;
                setflags_q <= in_setflags;
                err_q      <= op_err;
                cnt        <= op_err ? '0 : load_val;
            end else if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                if (err_q) begin
                    out_result <= '0;
                    out_co     <= 1'b0;
                    out_err    <= 1'b1;
                end else begin
                    out_result <= alu_out;
                    out_co     <= alu_co;
                    out_err    <= 1'b0;
                    if (setflags_q) begin
                        flags_nzcv <= {alu_negativo, alu_cero, alu_acarreo, alu_desbordamiento};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural alu model on the alu_* side.
module tb_alu_exec_ctrl;

    localparam int WIDTH = 23;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH:0]   in_a = '0;
    logic [WIDTH:0]   in_b = '0;
    logic [1:0]       in_op = 2'b00;
    logic             in_ci = 1'b0;
    logic             in_setflags = 1'b0;
    logic [WIDTH:0]   alu_a;
    logic [WIDTH:0]   alu_b;
    logic [1:0]       alu_opCode;
    logic             alu_ci;
    logic [WIDTH:0]   alu_out;
    logic             alu_co;
    logic             alu_negativo;
    logic             alu_cero;
    logic             alu_acarreo;
    logic             alu_desbordamiento;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH:0]   out_result;
    logic             out_co;
    logic             out_err;
    logic [3:0]       flags_nzcv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(WIDTH), .ADD_CYC(1), .MUL_CYC(2), .DIV_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_ci(in_ci), .in_setflags(in_setflags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opCode(alu_opCode), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_co(alu_co), .alu_negativo(alu_negativo), .alu_cero(alu_cero),
        .alu_acarreo(alu_acarreo), .alu_desbordamiento(alu_desbordamiento),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_co(out_co), .out_err(out_err), .flags_nzcv(flags_nzcv)
    );

    // Behavioural alu: add with carry/overflow, truncating mul, integer div
    always_comb begin
        logic [WIDTH+1:0] sum;
        sum                = '0;
        alu_out            = '0;
        alu_co             = 1'b0;
        alu_desbordamiento = 1'b0;
        case (alu_opCode)
            2'b00: begin
                sum                = {1'b0, alu_a} + {1'b0, alu_b} + {{(WIDTH+1){1'b0}}, alu_ci};
                alu_out            = sum[WIDTH:0];
                alu_co             = sum[WIDTH+1];
                alu_desbordamiento = (alu_a[WIDTH] == alu_b[WIDTH]) && (sum[WIDTH] != alu_a[WIDTH]);
            end
            2'b01:   alu_out = alu_a * alu_b;
            2'b10:   alu_out = (alu_b != '0) ? alu_a / alu_b : '0;
            default: alu_out = '0;
        endcase
        alu_negativo = alu_out[WIDTH];
        alu_cero     = (alu_out == '0);
        alu_acarreo  = alu_co;
    end

    typedef struct {
        logic [WIDTH:0] a;
        logic [WIDTH:0] b;
        logic [1:0]     op;
        logic           ci;
        logic           sf;
        logic [WIDTH:0] res;
        logic           co;
        logic           err;
        logic [3:0]     nzcv;
        int             lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_op = v.op; in_ci = v.ci; in_setflags = v.sf;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk({tag, "_alu_a_hold"}, 32'(alu_a), 32'(v.a));
            chk({tag, "_alu_b_hold"}, 32'(alu_b), 32'(v.b));
            chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_result"}, 32'(out_result), 32'(v.res));
        chk({tag, "_co"}, 32'(out_co), 32'(v.co));
        chk({tag, "_err"}, 32'(out_err), 32'(v.err));
        chk({tag, "_nzcv"}, 32'(flags_nzcv), 32'(v.nzcv));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t bp;
        //          a            b           op     ci    sf    res          co    err   nzcv     lat
        vecs[0]  = '{24'd5,      24'd5,      2'b00, 1'b0, 1'b1, 24'd10,      1'b0, 1'b0, 4'b0000, 1};
        vecs[1]  = '{24'd13,     24'd3,      2'b01, 1'b0, 1'b0, 24'd39,      1'b0, 1'b0, 4'b0000, 2};
        vecs[2]  = '{24'd13,     24'd3,      2'b10, 1'b0, 1'b0, 24'd4,       1'b0, 1'b0, 4'b0000, 4};
        vecs[3]  = '{24'd0,      24'd0,      2'b00, 1'b0, 1'b1, 24'd0,       1'b0, 1'b0, 4'b0100, 1};
        vecs[4]  = '{24'd7,      24'd0,      2'b10, 1'b0, 1'b1, 24'd0,       1'b0, 1'b1, 4'b0100, 1};
        vecs[5]  = '{24'd9,      24'd2,      2'b11, 1'b0, 1'b1, 24'd0,       1'b0, 1'b1, 4'b0100, 1};
        vecs[6]  = '{24'hFFFFFF, 24'd1,      2'b00, 1'b0, 1'b1, 24'd0,       1'b1, 1'b0, 4'b0110, 1};
        vecs[7]  = '{24'h7FFFFF, 24'd1,      2'b00, 1'b0, 1'b1, 24'h800000,  1'b0, 1'b0, 4'b1001, 1};
        vecs[8]  = '{24'd1,      24'd1,      2'b00, 1'b1, 1'b0, 24'd3,       1'b0, 1'b0, 4'b1001, 1};
        vecs[9]  = '{24'd1000,   24'd1000,   2'b01, 1'b0, 1'b1, 24'h0F4240,  1'b0, 1'b0, 4'b0000, 2};
        vecs[10] = '{24'd0,      24'd5,      2'b10, 1'b0, 1'b1, 24'd0,       1'b0, 1'b0, 4'b0100, 4};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready_held", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_op", 32'(alu_opCode), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_nzcv", 32'(flags_nzcv), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // backpressure: writeback stalls 3 cycles while decode keeps pushing
        @(negedge clk);
        in_valid = 1'b1; in_a = 24'd2; in_b = 24'd3; in_op = 2'b00; in_ci = 1'b0; in_setflags = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 24'd99; in_b = 24'd1; in_op = 2'b01;
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_result_held", 32'(out_result), 32'd5);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_alu_a_kept", 32'(alu_a), 32'd2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_result_kept", 32'(out_result), 32'd5);
        chk("bp_nzcv_kept", 32'(flags_nzcv), 32'b0100);

        // reset two cycles into a divide
        @(negedge clk);
        in_valid = 1'b1; in_a = 24'd13; in_b = 24'd3; in_op = 2'b10; in_setflags = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_alu_a", 32'(alu_a), 32'd0);
        chk("mrst_alu_b", 32'(alu_b), 32'd0);
        chk("mrst_alu_op", 32'(alu_opCode), 32'd0);
        chk("mrst_result", 32'(out_result), 32'd0);
        chk("mrst_nzcv", 32'(flags_nzcv), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("mrst_no_stale_valid", 32'(out_valid), 32'd0);
        end
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        bp = '{24'd5, 24'd5, 2'b00, 1'b0, 1'b1, 24'd10, 1'b0, 1'b0, 4'b0000, 1};
        run_op(bp, "post_rst_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
